// File: rtl/usb_tx_pkg.sv
// Shared types and default timing constants for the USB TX bit sequencer.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STUFF  = 2'd2
    } tx_seq_state_t;

    localparam int DEF_CLKS_PER_BIT  = 8;
    localparam int DEF_BITS_PER_BYTE = 8;

endpackage

// File: rtl/tx_tick_counter.sv
// 1-based tick counter: counts 1..MAX_COUNT, wraps back to 1, clear forces 1.
module tx_tick_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // NOTE: assigning the hold value first keeps this always_comb latch-free.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = ONE;
        end else if (en_i) begin
            cnt_d = (cnt_q == MAX_VAL) ? ONE : cnt_q + ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= ONE;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/usb_tx_bit_sequencer.sv
// USB TX bit timing: clock-per-bit and bit-per-byte counters plus the IDLE/ACTIVE/STUFF FSM
// that emits shift, stuff-insert and byte-load strobes to the TX datapath.
module usb_tx_bit_sequencer
    import usb_tx_pkg::*;
#(
    parameter  int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
    parameter  int BITS_PER_BYTE = DEF_BITS_PER_BYTE,
    localparam int CW            = $clog2(CLKS_PER_BIT + 1),
    localparam int BW            = $clog2(BITS_PER_BYTE + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          tx_start,
    input  logic          tx_stop,
    input  logic          tx_abort,
    input  logic          stuff_req,
    output logic          busy,
    output logic          shift_strobe,
    output logic          stuff_strobe,
    output logic          byte_done,
    output logic          tx_done,
    output logic [BW-1:0] bit_index
);

    tx_seq_state_t state_q, state_d;
    logic          stop_pending_q, stop_pending_d;
    logic          tx_done_q, tx_done_d;
    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_cnt;
    logic          bit_end;
    logic          last_bit;
    logic          first_bit;
    logic          stop_eff;

    tx_tick_counter #(.WIDTH(CW), .MAX_COUNT(CLKS_PER_BIT)) u_clk_counter (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear_i (tx_abort),
        .en_i    (busy),
        .cnt_o   (clk_cnt)
    );

    tx_tick_counter #(.WIDTH(BW), .MAX_COUNT(BITS_PER_BYTE)) u_bit_counter (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear_i (tx_abort),
        .en_i    (shift_strobe),
        .cnt_o   (bit_cnt)
    );

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign busy         = (state_q != IDLE);
    assign bit_end      = busy && (clk_cnt == CW'(CLKS_PER_BIT));
    assign shift_strobe = bit_end && (state_q == ACTIVE);
    assign stuff_strobe = bit_end && (state_q == STUFF);
    assign last_bit     = (bit_cnt == BW'(BITS_PER_BYTE));
    assign first_bit    = (bit_cnt == BW'(1));
    assign byte_done    = shift_strobe && last_bit;
    assign tx_done      = tx_done_q;
    assign bit_index    = bit_cnt;

    // A stop arriving on the boundary cycle itself still ends the frame there.
    assign stop_eff = stop_pending_q || tx_stop;

    always_comb begin
        state_d        = state_q;
        stop_pending_d = stop_pending_q;
        tx_done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_start) state_d = ACTIVE;
            end
            ACTIVE: begin
                stop_pending_d = stop_eff;
                if (bit_end) begin
                    if (stuff_req) begin
                        state_d = STUFF;
                    end else if (last_bit && stop_eff) begin
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end
                end
            end
            STUFF: begin
                stop_pending_d = stop_eff;
                if (bit_end) begin
                    if (first_bit && stop_eff) begin
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        state_d = ACTIVE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) stop_pending_d = 1'b0;
        if (tx_abort) begin
            state_d        = IDLE;
            stop_pending_d = 1'b0;
            tx_done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            stop_pending_q <= 1'b0;
            tx_done_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            stop_pending_q <= stop_pending_d;
            tx_done_q      <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_usb_tx_bit_sequencer.sv
// Bench for usb_tx_bit_sequencer: directed timing scenarios plus randomized traffic
// compared every cycle against a bit-period/byte-position model.
module tb_usb_tx_bit_sequencer;

    localparam int CPB = 8;
    localparam int BPB = 8;
    localparam int BW  = $clog2(BPB + 1);

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic tx_start = 1'b0;
    logic tx_stop = 1'b0;
    logic tx_abort = 1'b0;
    logic stuff_req = 1'b0;
    logic busy, shift_strobe, stuff_strobe, byte_done, tx_done;
    logic [BW-1:0] bit_index;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    usb_tx_bit_sequencer #(.CLKS_PER_BIT(CPB), .BITS_PER_BYTE(BPB)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .tx_start     (tx_start),
        .tx_stop      (tx_stop),
        .tx_abort     (tx_abort),
        .stuff_req    (stuff_req),
        .busy         (busy),
        .shift_strobe (shift_strobe),
        .stuff_strobe (stuff_strobe),
        .byte_done    (byte_done),
        .tx_done      (tx_done),
        .bit_index    (bit_index)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: position inside the current bit period, which data bit of the byte is next,
    // whether the current period is a stuff bit, and whether a stop has been requested.
    typedef struct packed {
        bit busy;
        bit stuff;
        bit stop;
        bit done;
        int tick;
        int bitn;
    } model_t;

    function automatic model_t model_idle();
        model_t r;
        r.busy = 1'b0; r.stuff = 1'b0; r.stop = 1'b0; r.done = 1'b0;
        r.tick = 1; r.bitn = 1;
        return r;
    endfunction

    function automatic model_t model_step(model_t c, logic start, logic stop, logic abort, logic sreq);
        model_t n = c;
        bit stop_eff;
        bit boundary;
        n.done = 1'b0;
        if (abort) begin
            n = model_idle();
        end else if (!c.busy) begin
            n.stop = 1'b0;
            if (start) n.busy = 1'b1;
        end else begin
            stop_eff = c.stop || stop;
            n.stop = stop_eff;
            if (c.tick < CPB) begin
                n.tick = c.tick + 1;
            end else begin
                n.tick = 1;
                if (!c.stuff) begin
                    boundary = (c.bitn == BPB);
                    n.bitn = boundary ? 1 : c.bitn + 1;
                    if (sreq) n.stuff = 1'b1;
                    else if (boundary && stop_eff) begin
                        n.busy = 1'b0; n.stop = 1'b0; n.done = 1'b1;
                    end
                end else begin
                    n.stuff = 1'b0;
                    if (c.bitn == 1 && stop_eff) begin
                        n.busy = 1'b0; n.stop = 1'b0; n.done = 1'b1;
                    end
                end
            end
        end
        return n;
    endfunction

    model_t m = model_idle();

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) m <= model_idle();
        else        m <= model_step(m, tx_start, tx_stop, tx_abort, stuff_req);
    end

    // Every cycle, on the falling edge, outputs must match the model.
    always @(negedge clk) begin
        check("cycle_outputs",
              32'({busy, shift_strobe, stuff_strobe, byte_done, tx_done, bit_index}),
              32'({m.busy,
                   m.busy && m.tick == CPB && !m.stuff,
                   m.busy && m.tick == CPB && m.stuff,
                   m.busy && m.tick == CPB && !m.stuff && m.bitn == BPB,
                   m.done,
                   BW'(m.bitn)}));
    end

    task automatic clk1();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_tx();
        tx_start = 1'b1;
        cyc = 0;
        clk1();
        tx_start = 1'b0;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) clk1();
    endtask

    task automatic abort_tx();
        tx_abort = 1'b1;
        clk1();
        tx_abort = 1'b0;
    endtask

    function automatic logic sig(input int code);
        case (code)
            0:       return shift_strobe;
            1:       return stuff_strobe;
            2:       return byte_done;
            3:       return tx_done;
            default: return busy;
        endcase
    endfunction

    task automatic wait_check(input int code, input int budget, input string name, input int exp_cyc);
        int at = -1;
        for (int i = 0; i < budget; i++) begin
            clk1();
            if (sig(code)) begin
                at = cyc;
                break;
            end
        end
        check(name, 32'(at), 32'(exp_cyc));
    endtask

    initial begin
        int shifts, bds, bad, lowbusy, spurious;

        #2 n_rst = 1'b0;
        @(negedge clk);
        check("reset_state", 32'({busy, shift_strobe, stuff_strobe, byte_done, tx_done, bit_index}),
              32'({5'b0, BW'(1)}));
        @(negedge clk);
        n_rst = 1'b1;
        clk1();

        // Asynchronous reset in the middle of bit 3, clock count 5.
        start_tx();
        run_to(21);
        check("t1_bit_index_before_reset", 32'(bit_index), 32'd3);
        #2 n_rst = 1'b0;
        #1 check("t1_async_reset", 32'({busy, shift_strobe, stuff_strobe, byte_done, tx_done, bit_index}),
                 32'({5'b0, BW'(1)}));
        @(negedge clk);
        n_rst = 1'b1;
        clk1();

        // 16 bytes with no stuffing.
        start_tx();
        shifts = 0; bds = 0; bad = 0; lowbusy = 0;
        for (int i = 0; i < 16 * 64; i++) begin
            if (i > 0) clk1();
            if (shift_strobe) begin
                shifts++;
                if (cyc % CPB != 0) bad++;
            end
            if (byte_done) begin
                bds++;
                if (cyc % 64 != 0) bad++;
            end
            if (!busy) lowbusy++;
        end
        check("t2_shift_count", 32'(shifts), 32'd128);
        check("t2_byte_done_count", 32'(bds), 32'd16);
        check("t2_misplaced_strobes", 32'(bad), 32'd0);
        check("t2_busy_dropped", 32'(lowbusy), 32'd0);
        abort_tx();

        // Stuff bit after data bit 3.
        start_tx();
        run_to(24);
        check("t3_bit3_shift", 32'({shift_strobe, bit_index}), 32'({1'b1, BW'(3)}));
        stuff_req = 1'b1;
        clk1();
        stuff_req = 1'b0;
        wait_check(1, 100, "t3_stuff_strobe_cycle", 32);
        check("t3_bit_index_in_stuff", 32'(bit_index), 32'd4);
        wait_check(2, 100, "t3_byte_done_cycle", 72);
        abort_tx();

        // Stop requested mid byte 2.
        start_tx();
        run_to(81);
        tx_stop = 1'b1;
        clk1();
        tx_stop = 1'b0;
        wait_check(3, 200, "t4_tx_done_cycle", 129);
        check("t4_busy_after_done", 32'(busy), 32'd0);

        // Stop pending, then a stuff request on bit 8: frame ends after the stuff bit.
        start_tx();
        run_to(30);
        tx_stop = 1'b1;
        clk1();
        tx_stop = 1'b0;
        run_to(64);
        check("t4b_byte_done_at_64", 32'(byte_done), 32'd1);
        stuff_req = 1'b1;
        clk1();
        stuff_req = 1'b0;
        wait_check(1, 100, "t4b_stuff_strobe_cycle", 72);
        wait_check(3, 100, "t4b_tx_done_cycle", 73);
        check("t4b_busy_after_done", 32'(busy), 32'd0);

        // Abort at clock count 4, then restart.
        start_tx();
        run_to(4);
        tx_abort = 1'b1;
        clk1();
        tx_abort = 1'b0;
        check("t5_abort_outputs", 32'({busy, shift_strobe, tx_done}), 32'd0);
        spurious = 0;
        repeat (20) begin
            clk1();
            if (busy || shift_strobe || tx_done) spurious++;
        end
        check("t5_quiet_after_abort", 32'(spurious), 32'd0);
        start_tx();
        wait_check(0, 50, "t5_restart_first_shift", 8);
        abort_tx();

        // Stop in IDLE and start while busy are both ignored; abort beats start in IDLE.
        tx_stop = 1'b1;
        clk1();
        tx_stop = 1'b0;
        tx_start = 1'b1;
        tx_abort = 1'b1;
        clk1();
        tx_start = 1'b0;
        tx_abort = 1'b0;
        check("t6_abort_beats_start", 32'(busy), 32'd0);
        start_tx();
        run_to(3);
        tx_start = 1'b1;
        clk1();
        tx_start = 1'b0;
        wait_check(2, 100, "t6_byte_done_unchanged", 64);
        run_to(130);
        check("t6_idle_stop_ignored", 32'(busy), 32'd1);
        abort_tx();

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 6000; i++) begin
            tx_start  = ($urandom_range(15) == 0);
            tx_stop   = ($urandom_range(127) == 0);
            tx_abort  = ($urandom_range(499) == 0);
            stuff_req = ($urandom_range(5) == 0);
            clk1();
        end
        tx_start = 1'b0; tx_stop = 1'b0; tx_abort = 1'b0; stuff_req = 1'b0;
        clk1();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
